// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO read-side drain controller.
// State encoding and default data width.
package fifo_drain_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Purpose: 2-entry in-order buffer, head word drives the downstream stream.
// Latency: push visible at head on the next cycle when empty.
// Backpressure: caller must never push into a full buffer without popping.
module drain_skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;

    assign head = q0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q0  <= '0;
            q1  <= '0;
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) q0 <= push_data;
                    else             q1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    q0  <= q1;
                    q1  <= '0;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; new word goes behind the survivor.
                    if (occ == 2'd1) begin
                        q0 <= push_data;
                    end else begin
                        q0 <= q1;
                        q1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Purpose: drains a synchronous FIFO onto a ready/valid stream, counts words, flags underflow.
// Latency: fifo_rd in cycle N -> out_valid in cycle N+2 (empty buffer); 1 word/cycle sustained.
// Backpressure: reads are throttled so buffered + in-flight words never exceed 2.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_under,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic             under_err
);

    state_t     state;
    state_t     state_nxt;
    logic       inflight;
    logic [1:0] occ;
    logic [2:0] pend;
    logic       pop;
    logic       push;

    assign pop       = out_valid & out_ready;
    assign push      = inflight & fifo_valid;
    assign pend      = {1'b0, occ} + {2'b00, inflight};
    assign out_valid = (occ != 2'd0);
    assign busy      = (state != ST_IDLE);

    // A read is allowed only if the word it returns is guaranteed a buffer slot.
    assign fifo_rd = (state == ST_RUN) && !fifo_empty &&
                     ((pend <= 3'd1) || ((pend == 3'd2) && pop));

    drain_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .head      (out_data),
        .occ       (occ)
    );

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_RUN;
            ST_RUN:   if (!en) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!inflight && (occ == 2'd0)) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            inflight  <= 1'b0;
            word_cnt  <= '0;
            under_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd;
            if (pop) word_cnt <= word_cnt + 1'b1;
            if (fifo_under)   under_err <= 1'b1;
            else if (clr_err) under_err <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
Read-side controller for the team's 16-bit synchronous FIFO. It issues `rd` to the FIFO while the FIFO is non-empty. It absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer and presents words on a ready/valid stream to the downstream consumer. It also counts drained words and records FIFO underflow events. Instantiated alongside the FIFO; its FIFO-side ports connect one-to-one to the FIFO's `rd`/`dout`/`empty`/`valid`/`under`.

Parameters:
WIDTH, 16, data word width (matches FIFO `din`/`dout`)
CNT_W, 16, width of drained-word counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on the clock edge)
en  input  1  1 = drain FIFO; 0 = stop issuing reads and flush
clr_err  input  1  1-cycle pulse clears under_err
fifo_empty  input  1  FIFO empty flag
fifo_valid  input  1  FIFO read data valid (one cycle after rd)
fifo_dout  input  WIDTH  FIFO read data
fifo_under  input  1  FIFO underflow flag
fifo_rd  output  1  read strobe to FIFO
out_data  output  WIDTH  downstream data (buffer head)
out_valid  output  1  downstream data valid
out_ready  input  1  downstream accepts when out_valid & out_ready
busy  output  1  state != IDLE
done  output  1  1-cycle pulse on DRAIN->IDLE
word_cnt  output  CNT_W  words accepted downstream since reset
under_err  output  1  sticky FIFO underflow indicator

Behaviour:
- Reset (rst=0 at edge): state=IDLE; occ=0; inflight=0; buffer cleared. Outputs: fifo_rd=0, out_valid=0, out_data=0, busy=0, done=0, word_cnt=0, under_err=0. Reset mid-operation discards buffered and in-flight words.
- FSM states:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when inflight=0 and occ=0; done=1 on that transition.
  - en=1 during DRAIN is ignored. Re-entry to RUN goes through IDLE, so the earliest RUN is 2 cycles after DRAIN exits.
- pop = out_valid & out_ready.
- fifo_rd (combinational) = (state==RUN) & !fifo_empty & ((occ+inflight)<=1 | ((occ+inflight)==2 & pop)). The buffer therefore never overflows; this gives sustained 1 word/cycle with out_ready held high.
- inflight <= fifo_rd (registered). The buffer pushes fifo_dout only when inflight=1 & fifo_valid=1. A fifo_valid seen with inflight=0 is ignored.
- inflight=1 with fifo_valid=0 is treated as a lost read: no push, inflight clears.
- Buffer: 2-entry FIFO, head at out_data. out_valid = (occ>0).
  - Push and pop in the same cycle: occ unchanged, order preserved.
  - Push with occ=2 and no pop is impossible by construction. The bench asserts it never happens.
- Latency: fifo_rd at cycle N -> word captured at end of N+1 -> out_valid=1 in cycle N+2 (when buffer was empty).
- word_cnt += 1 on each pop; wraps 2^CNT_W-1 -> 0.
- under_err set on fifo_under=1. Cleared on clr_err=1 unless fifo_under=1 in the same cycle (set wins).
- fifo_empty=1 in RUN: no rd. Data already buffered keeps draining downstream.

Decomposition:
- Shared package: state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2), default WIDTH=16.
- One natural sub-module: drain_skid_buf, the 2-entry push/pop buffer with occ output.
- FSM, read-issue logic and counters live in fifo_drain.

Test Plan:
- Reset: hold rst=0 for 10 cycles with en=1 and fifo_valid toggling -> all outputs 0, word_cnt=0, fifo_rd=0 throughout.
- Stream: FIFO preloaded with 1..9, en=1, out_ready=1 -> fifo_rd high 9 consecutive cycles; out_data 1..9 in order starting 2 cycles after the first rd; word_cnt=9.
- Backpressure: preload 1..9, out_ready=0 -> exactly 2 reads issued, then fifo_rd=0 and out_data=1 held. Raise out_ready -> remaining words 1..9 delivered in order with no loss or duplication.
- Stop/flush: en dropped after 3 reads -> no further fifo_rd; in-flight and buffered words (1,2,3) delivered; done pulses once; busy=0 afterwards.
- Empty gap: FIFO empties after 4 words, then refills with 5,6 -> rd stalls while fifo_empty=1 and resumes; output sequence is 1..6.
- Error/wrap: pulse fifo_under -> under_err=1 until clr_err. With CNT_W=4, deliver 17 words -> word_cnt=1.
